// File: rtl/ex_mem_stage.sv
// EX/MEM elastic pipeline stage: valid/ready on both sides, 2-entry skid
// buffer, flush, bubble-gated memory/regfile write controls, saturating
// back-pressure counter. All state advances on the falling clock edge.
module ex_mem_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 4,
    parameter int unsigned STAT_WIDTH     = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     ALUResult_in,
    input  logic [DATA_WIDTH-1:0]     registerFileDataB_in,
    input  logic [REG_ADDR_WIDTH-1:0] registerFileWrite_in,
    input  logic                      memRead_in,
    input  logic                      memWrite_in,
    input  logic                      memToReg_in,
    input  logic                      regWrite_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     ALUResult,
    output logic [DATA_WIDTH-1:0]     registerFileDataB,
    output logic [REG_ADDR_WIDTH-1:0] registerFileWrite,
    output logic                      memRead,
    output logic                      memWrite,
    output logic                      memToReg,
    output logic                      regWrite,
    output logic [1:0]                occupancy,
    output logic [STAT_WIDTH-1:0]     stall_count
);

    localparam logic [STAT_WIDTH-1:0] STALL_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Head entry (drives the outputs); write controls are stored pre-gated
    logic [DATA_WIDTH-1:0]     alu_q, alu_d;
    logic [DATA_WIDTH-1:0]     data_b_q, data_b_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      mem_read_q, mem_read_d;
    logic                      mem_write_q, mem_write_d;
    logic                      mem_to_reg_q, mem_to_reg_d;
    logic                      reg_write_q, reg_write_d;

    // Skid entry
    logic [DATA_WIDTH-1:0]     skid_alu_q, skid_alu_d;
    logic [DATA_WIDTH-1:0]     skid_data_b_q, skid_data_b_d;
    logic [REG_ADDR_WIDTH-1:0] skid_rd_q, skid_rd_d;
    logic                      skid_mem_read_q, skid_mem_read_d;
    logic                      skid_mem_write_q, skid_mem_write_d;
    logic                      skid_mem_to_reg_q, skid_mem_to_reg_d;
    logic                      skid_reg_write_q, skid_reg_write_d;

    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic [1:0]                occ_q, occ_d;
    logic [STAT_WIDTH-1:0]     stall_q, stall_d;

    logic accept;
    logic pop;
    logic load_head;
    logic load_skid;
    logic skid_to_head;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    // State register and all datapath/status registers
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q           <= ST_EMPTY;
            alu_q             <= '0;
            data_b_q          <= '0;
            rd_q              <= '0;
            mem_read_q        <= 1'b0;
            mem_write_q       <= 1'b0;
            mem_to_reg_q      <= 1'b0;
            reg_write_q       <= 1'b0;
            skid_alu_q        <= '0;
            skid_data_b_q     <= '0;
            skid_rd_q         <= '0;
            skid_mem_read_q   <= 1'b0;
            skid_mem_write_q  <= 1'b0;
            skid_mem_to_reg_q <= 1'b0;
            skid_reg_write_q  <= 1'b0;
            in_ready_q        <= 1'b1;
            out_valid_q       <= 1'b0;
            occ_q             <= 2'd0;
            stall_q           <= '0;
        end else begin
            state_q           <= state_d;
            alu_q             <= alu_d;
            data_b_q          <= data_b_d;
            rd_q              <= rd_d;
            mem_read_q        <= mem_read_d;
            mem_write_q       <= mem_write_d;
            mem_to_reg_q      <= mem_to_reg_d;
            reg_write_q       <= reg_write_d;
            skid_alu_q        <= skid_alu_d;
            skid_data_b_q     <= skid_data_b_d;
            skid_rd_q         <= skid_rd_d;
            skid_mem_read_q   <= skid_mem_read_d;
            skid_mem_write_q  <= skid_mem_write_d;
            skid_mem_to_reg_q <= skid_mem_to_reg_d;
            skid_reg_write_q  <= skid_reg_write_d;
            in_ready_q        <= in_ready_d;
            out_valid_q       <= out_valid_d;
            occ_q             <= occ_d;
            stall_q           <= stall_d;
        end
    end

    // Next-state logic and load strobes; flush overrides every other event
    always_comb begin
        state_d      = state_q;
        load_head    = 1'b0;
        load_skid    = 1'b0;
        skid_to_head = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        load_head = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        load_head = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        skid_to_head = 1'b1;
                        state_d      = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Payload movement, bubble gating and registered status outputs
    always_comb begin
        alu_d             = alu_q;
        data_b_d          = data_b_q;
        rd_d              = rd_q;
        mem_read_d        = mem_read_q;
        mem_write_d       = mem_write_q;
        mem_to_reg_d      = mem_to_reg_q;
        reg_write_d       = reg_write_q;
        skid_alu_d        = skid_alu_q;
        skid_data_b_d     = skid_data_b_q;
        skid_rd_d         = skid_rd_q;
        skid_mem_read_d   = skid_mem_read_q;
        skid_mem_write_d  = skid_mem_write_q;
        skid_mem_to_reg_d = skid_mem_to_reg_q;
        skid_reg_write_d  = skid_reg_write_q;
        in_ready_d        = (state_d != ST_FULL);
        out_valid_d       = (state_d != ST_EMPTY);
        occ_d             = 2'd0;
        stall_d           = stall_q;

        if (load_head) begin
            alu_d        = ALUResult_in;
            data_b_d     = registerFileDataB_in;
            rd_d         = registerFileWrite_in;
            mem_read_d   = memRead_in;
            mem_write_d  = memWrite_in;
            mem_to_reg_d = memToReg_in;
            reg_write_d  = regWrite_in;
        end else if (skid_to_head) begin
            alu_d        = skid_alu_q;
            data_b_d     = skid_data_b_q;
            rd_d         = skid_rd_q;
            mem_read_d   = skid_mem_read_q;
            mem_write_d  = skid_mem_write_q;
            mem_to_reg_d = skid_mem_to_reg_q;
            reg_write_d  = skid_reg_write_q;
        end

        if (load_skid) begin
            skid_alu_d        = ALUResult_in;
            skid_data_b_d     = registerFileDataB_in;
            skid_rd_d         = registerFileWrite_in;
            skid_mem_read_d   = memRead_in;
            skid_mem_write_d  = memWrite_in;
            skid_mem_to_reg_d = memToReg_in;
            skid_reg_write_d  = regWrite_in;
        end

        // A bubble must never issue a memory access or register write
        if (state_d == ST_EMPTY) begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            reg_write_d = 1'b0;
        end

        unique case (state_d)
            ST_ONE:  occ_d = 2'd1;
            ST_FULL: occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase

        if (out_valid_q && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STAT_WIDTH'(1);
        end
    end

    assign in_ready          = in_ready_q;
    assign out_valid         = out_valid_q;
    assign ALUResult         = alu_q;
    assign registerFileDataB = data_b_q;
    assign registerFileWrite = rd_q;
    assign memRead           = mem_read_q;
    assign memWrite          = mem_write_q;
    assign memToReg          = mem_to_reg_q;
    assign regWrite          = reg_write_q;
    assign occupancy         = occ_q;
    assign stall_count       = stall_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_ex_mem_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned SW = 16;

    typedef struct {
        logic [DW-1:0] alu;
        logic [DW-1:0] b;
        logic [AW-1:0] rd;
        logic          mr;
        logic          mw;
        logic          mtr;
        logic          rw;
    } entry_t;

    logic          clock;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] alu_in;
    logic [DW-1:0] b_in;
    logic [AW-1:0] rd_in;
    logic          mr_in, mw_in, mtr_in, rw_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] alu_o;
    logic [DW-1:0] b_o;
    logic [AW-1:0] rd_o;
    logic          mr_o, mw_o, mtr_o, rw_o;
    logic [1:0]    occ_o;
    logic [SW-1:0] stall_o;

    // Second instance with a 2-bit counter for saturation
    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_alu, s_b;
    logic [AW-1:0] s_rd;
    logic          s_mr, s_mw, s_mtr, s_rw;
    logic [1:0]    s_occ;
    logic [1:0]    s_stall;

    ex_mem_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .STAT_WIDTH(SW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUResult_in(alu_in), .registerFileDataB_in(b_in),
        .registerFileWrite_in(rd_in),
        .memRead_in(mr_in), .memWrite_in(mw_in),
        .memToReg_in(mtr_in), .regWrite_in(rw_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(alu_o), .registerFileDataB(b_o),
        .registerFileWrite(rd_o),
        .memRead(mr_o), .memWrite(mw_o), .memToReg(mtr_o), .regWrite(rw_o),
        .occupancy(occ_o), .stall_count(stall_o)
    );

    ex_mem_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .STAT_WIDTH(2)) u_sat (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .ALUResult_in(alu_in), .registerFileDataB_in(b_in),
        .registerFileWrite_in(rd_in),
        .memRead_in(mr_in), .memWrite_in(mw_in),
        .memToReg_in(mtr_in), .regWrite_in(rw_in),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .ALUResult(s_alu), .registerFileDataB(s_b),
        .registerFileWrite(s_rd),
        .memRead(s_mr), .memWrite(s_mw), .memToReg(s_mtr), .regWrite(s_rw),
        .occupancy(s_occ), .stall_count(s_stall)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    // Reference model state
    entry_t        mq[$];
    entry_t        disp;
    int unsigned   m_stall;
    int unsigned   m_stall_sat;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic entry_t zero_entry();
        entry_t e;
        e.alu = '0; e.b = '0; e.rd = '0;
        e.mr = 1'b0; e.mw = 1'b0; e.mtr = 1'b0; e.rw = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        disp        = zero_entry();
        m_stall     = 0;
        m_stall_sat = 0;
    endtask

    // One falling edge of the reference stage, using the driven inputs
    task automatic model_edge();
        bit     have;
        bit     acc;
        bit     pp;
        entry_t e;
        have = (mq.size() > 0);
        acc  = in_valid && (mq.size() < 2);
        pp   = have && out_ready;
        if (have && !out_ready) begin
            if (m_stall < 65535) m_stall++;
            if (m_stall_sat < 3) m_stall_sat++;
        end
        if (flush) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) begin
                e.alu = alu_in; e.b = b_in; e.rd = rd_in;
                e.mr = mr_in; e.mw = mw_in; e.mtr = mtr_in; e.rw = rw_in;
                mq.push_back(e);
            end
        end
        if (mq.size() > 0) disp = mq[0];
    endtask

    task automatic compare_all();
        bit v;
        v = (mq.size() > 0);
        check("out_valid",  64'(out_valid), 64'(v));
        check("in_ready",   64'(in_ready),  64'(mq.size() < 2));
        check("occupancy",  64'(occ_o),     64'(mq.size()));
        check("ALUResult",  64'(alu_o),     64'(disp.alu));
        check("dataB",      64'(b_o),       64'(disp.b));
        check("regfileWr",  64'(rd_o),      64'(disp.rd));
        check("memRead",    64'(mr_o),      64'(disp.mr & v));
        check("memWrite",   64'(mw_o),      64'(disp.mw & v));
        check("memToReg",   64'(mtr_o),     64'(disp.mtr));
        check("regWrite",   64'(rw_o),      64'(disp.rw & v));
        check("stall",      64'(stall_o),   64'(m_stall));
        check("stall_sat",  64'(s_stall),   64'(m_stall_sat));
    endtask

    // Advance one clock: falling edge updates model, check after rising edge
    task automatic tick();
        @(negedge clock);
        model_edge();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic v, input logic [DW-1:0] a, input logic ordy,
                          input logic fl, input logic mw, input logic rw, input logic [AW-1:0] rd);
        in_valid  = v;
        alu_in    = a;
        b_in      = a ^ 32'hA5A5_0000;
        rd_in     = rd;
        mr_in     = 1'b0;
        mw_in     = mw;
        mtr_in    = rw;
        rw_in     = rw;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic rand_in();
        in_valid  = ($urandom_range(0, 3) != 0);
        alu_in    = $urandom;
        b_in      = $urandom;
        rd_in     = AW'($urandom);
        mr_in     = 1'($urandom);
        mw_in     = 1'($urandom);
        mtr_in    = 1'($urandom);
        rw_in     = 1'($urandom);
        out_ready = ($urandom_range(0, 9) < 7);
        flush     = ($urandom_range(0, 15) == 0);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once
    task automatic pulse_reset();
        rand_in();
        #1 reset = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_occ",       64'(occ_o),     64'd0);
        check("rst_stall",     64'(stall_o),   64'd0);
        check("rst_alu",       64'(alu_o),     64'd0);
        check("rst_ctrl",      64'({mr_o, mw_o, mtr_o, rw_o, rd_o}), 64'd0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        model_reset();
        @(posedge clock);
        #1;
        check("init_out_valid", 64'(out_valid), 64'd0);
        check("init_in_ready",  64'(in_ready),  64'd1);
        check("init_occ",       64'(occ_o),     64'd0);
        check("init_stall",     64'(stall_o),   64'd0);
        check("init_alu",       64'(alu_o),     64'd0);
        #1 reset = 1'b0;
        compare_all();

        // Back-pressure: A, B fill head and skid, C is held off
        set_in(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        tick();
        check("bp_head_a", 64'(alu_o), 64'h10);
        set_in(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        tick();
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_occ_full",     64'(occ_o),    64'd2);
        set_in(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        tick();
        check("bp_head_still_a", 64'(alu_o),   64'h10);
        check("bp_stall_2",      64'(stall_o), 64'd2);
        out_ready = 1'b1;
        tick();
        check("bp_head_b", 64'(alu_o), 64'h20);
        tick();
        check("bp_head_c", 64'(alu_o), 64'h30);
        in_valid = 1'b0;
        tick();
        check("bp_drained", 64'(out_valid), 64'd0);

        // Flush while FULL with D offered in the same cycle
        set_in(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4);
        tick();
        set_in(1'b1, 32'h50, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4);
        tick();
        set_in(1'b1, 32'hD, 1'b0, 1'b1, 1'b1, 1'b1, 4'd4);
        tick();
        check("fl_occ",      64'(occ_o),     64'd0);
        check("fl_valid",    64'(out_valid), 64'd0);
        check("fl_memwrite", 64'(mw_o),      64'd0);
        check("fl_regwrite", 64'(rw_o),      64'd0);
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        check("fl_no_d", 64'(alu_o), 64'h40);

        // Streaming at full rate
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, DW'(i), 1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
            tick();
            check("st_alu", 64'(alu_o), 64'(i));
            check("st_rw",  64'(rw_o),  64'd1);
            check("st_rd",  64'(rd_o),  64'd5);
            check("st_occ", 64'(occ_o), 64'd1);
        end

        // Bubble gating after a store leaves with nothing behind it
        set_in(1'b1, 32'h77, 1'b1, 1'b0, 1'b1, 1'b1, 4'd6);
        tick();
        check("bub_mw_live", 64'(mw_o), 64'd1);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        check("bub_mw",   64'(mw_o),  64'd0);
        check("bub_rw",   64'(rw_o),  64'd0);
        check("bub_hold", 64'(alu_o), 64'h77);

        // Saturation of the 2-bit counter after a fresh reset
        pulse_reset();
        set_in(1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("sat_3",    64'(s_stall), 64'd3);
        check("sat_wide", 64'(stall_o), 64'd6);

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            tick();
            if ($urandom_range(0, 499) == 0) pulse_reset();
        end
        pulse_reset();
        for (int i = 0; i < 500; i++) begin
            rand_in();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised, elastic EX/MEM pipeline stage with a valid/ready handshake on both sides, a 2-entry skid buffer, flush, bubble gating of memory and register-file write controls, and a saturating back-pressure counter. It sits between the execute stage (ALU result, store data, destination register, control bits) and the data-memory stage. It lets the memory stage stall without a combinational ready path back into execute.

## Interface
- DATA_WIDTH, 32: width of ALU result and store data (registerFileDataB).
- REG_ADDR_WIDTH, 4: width of destination register index.
- STAT_WIDTH, 16: width of stall counter.

- clock  in  1  stage clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all buffered entries at the next falling edge.
- in_valid  in  1  execute stage presents an entry.
- in_ready  out  1  stage can accept an entry.
- ALUResult_in  in  DATA_WIDTH  ALU result / memory address.
- registerFileDataB_in  in  DATA_WIDTH  store data.
- registerFileWrite_in  in  REG_ADDR_WIDTH  destination register.
- memRead_in, memWrite_in, memToReg_in, regWrite_in  in  1 each  control bits.
- out_valid  out  1  memory stage has a valid entry.
- out_ready  in  1  memory stage consumes the entry.
- ALUResult, registerFileDataB  out  DATA_WIDTH  payload of head entry.
- registerFileWrite  out  REG_ADDR_WIDTH  destination of head entry.
- memRead, memWrite, memToReg, regWrite  out  1 each  head control bits; memRead, memWrite and regWrite are forced to 0 when out_valid=0.
- occupancy  out  2  entries held (0..2).
- stall_count  out  STAT_WIDTH  saturating count of back-pressured edges.

## Operation
- Storage: head register (drives outputs) and skid register, each with a valid bit. States: EMPTY (0 entries), ONE (head valid), FULL (head and skid valid).
- in_ready = !skid_valid. It is a registered signal, with no combinational path from out_ready.
- accept = in_valid & in_ready. pop = out_valid & out_ready.
- EMPTY: accept loads the head and moves to ONE.
- ONE:
  - accept & pop: the head takes the new entry; stay in ONE.
  - accept & !pop: the skid takes the new entry; move to FULL.
  - pop & !accept: move to EMPTY.
- FULL: no accept is possible. On pop, the skid moves into the head, the skid is cleared, and the stage moves to ONE.
- Entries leave in order. An entry is never duplicated or dropped, except by flush.
- flush has priority over all other events. At the edge, both valid bits are cleared and the stage goes to EMPTY. An entry offered in the same cycle is dropped. A pop in the same cycle still counts as consumed by the downstream stage.
- Payload registers load only on accept or skid-to-head transfer. Data is otherwise held, including after a flush; only the gated controls drop.
- memToReg is not gated; it is meaningful only while out_valid=1.
- stall_count increments on each falling edge where out_valid=1 and out_ready=0. It saturates at 2^STAT_WIDTH-1 and is cleared only by reset.
- occupancy is 0, 1 or 2 for EMPTY, ONE or FULL.

## Timing
- Reset (asynchronous, immediate):
  - valid bits and all payload registers are 0; state is EMPTY.
  - out_valid=0, in_ready=1, occupancy=0, stall_count=0.
  - All data and control outputs are 0.
- Latency: an entry accepted at falling edge N appears on the outputs with out_valid=1 immediately after edge N (1 edge).
- Throughput: 1 entry per clock while out_ready=1; occupancy stays at or below 1.
- out_ready dropping for one cycle fills the skid. in_ready falls after that edge and rises after the edge where the head is popped.
- Inputs and out_ready are sampled at the falling edge; outputs change only after a falling edge or on reset.
- Reset asserted mid-operation:
  - All entries are lost and outputs clear without waiting for a clock edge.
  - On deassertion, the first accept occurs at the next falling edge with in_valid=1.

## Test plan
- Reset: drive random inputs, pulse reset between edges -> outputs drop to 0 immediately; out_valid=0, in_ready=1, occupancy=0, stall_count=0.
- Streaming: out_ready=1; present ALUResult_in 1,2,3,4 on consecutive edges with regWrite_in=1 and registerFileWrite_in=5 -> ALUResult shows 1,2,3,4 one edge later each; regWrite=1, registerFileWrite=5; occupancy stays 1.
- Back-pressure:
  - Stimulus: out_ready=0 for 3 edges while offering A=0x10, B=0x20, C=0x30.
  - Required: head=A; skid=B; in_ready=0 after the second edge; C is held off; stall_count=2 or 3 as counted per rule.
  - Release: raise out_ready -> outputs are A, B, C in order with no loss.
- Flush while FULL, with in_valid=1 carrying D -> after the edge occupancy=0, out_valid=0, memWrite=0, regWrite=0; D never appears.
- Bubble gating: after a memWrite_in=1 entry is popped with no new input -> memWrite=0 and regWrite=0, while ALUResult still holds the last value.
- Saturation: STAT_WIDTH=2, hold out_valid=1 and out_ready=0 for 6 edges -> stall_count reaches 3 and stays there.
